// File: rtl/swu_pkg.sv
// Shared sliding-window geometry: derived constants, width helper and the
// collector state encoding, so the SWU and its receiver agree on window layout.
package swu_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } swu_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int eff_channels(input int ifm_channels, input int simd);
    return ifm_channels / simd;
  endfunction

  function automatic int window_beats(input int kh, input int kw,
                                      input int ifm_channels, input int simd);
    return kh * kw * eff_channels(ifm_channels, simd);
  endfunction

  function automatic int beat_width(input int simd, input int precision);
    return simd * precision;
  endfunction

  // Geometry of the default configuration.
  localparam int EFF_CHANNELS = eff_channels(2, 1);
  localparam int WINDOW_BEATS = window_beats(3, 3, 2, 1);
  localparam int BW           = beat_width(1, 8);

endpackage

// File: rtl/swu_pixel_counter.sv
// Output-pixel position tracker: column counts fastest, row advances on column
// wrap, both wrap explicitly so a new frame starts at (0,0) right away.
module swu_pixel_counter
  import swu_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int HEIGHT = 3,
  localparam int COL_W = clog2_min1(WIDTH),
  localparam int ROW_W = clog2_min1(HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             col_last_o,
  output logic             row_last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign col_last_o = (col_q == COL_W'(WIDTH - 1));
  assign row_last_o = (row_q == ROW_W'(HEIGHT - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (adv_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_last_o ? '0 : ROW_W'(row_q + 1'b1);
      end else begin
        col_d = COL_W'(col_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/swu_window_collector.sv
// Reassembles serialized SWU window beats into one wide word per output pixel
// and tags it with its (col,row) position and end-of-frame.
module swu_window_collector
  import swu_pkg::*;
#(
  parameter int SIMD          = 1,
  parameter int IFMChannels   = 2,
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 3,
  parameter int OFMWidth      = 3,
  parameter int OFMHeight     = 3,
  parameter int IP_PRECISION  = 8,
  localparam int BEAT_W    = beat_width(SIMD, IP_PRECISION),
  localparam int WIN_BEATS = window_beats(KERNEL_HEIGHT, KERNEL_WIDTH, IFMChannels, SIMD),
  localparam int COL_W     = clog2_min1(OFMWidth),
  localparam int ROW_W     = clog2_min1(OFMHeight)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BEAT_W-1:0]             ip_axis_tdata,
  input  logic                          ip_axis_tvalid,
  output logic                          ip_axis_tready,
  output logic [WIN_BEATS*BEAT_W-1:0]   op_axis_tdata,
  output logic                          op_axis_tvalid,
  input  logic                          op_axis_tready,
  output logic                          op_axis_tlast,
  output logic [COL_W-1:0]              op_col,
  output logic [ROW_W-1:0]              op_row,
  output logic                          frame_done
);

  localparam int IDX_W = clog2_min1(WIN_BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_BEATS - 1);

  swu_state_e                      state_q, state_d;
  logic [IDX_W-1:0]                beat_idx_q, beat_idx_d;
  logic [WIN_BEATS*BEAT_W-1:0]     data_q;
  logic                            frame_done_q;
  logic                            ready_c, valid_c, wr_en;
  logic [IDX_W-1:0]                wr_idx;
  logic                            op_hs, col_last, row_last;

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    ready_c    = 1'b0;
    valid_c    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = beat_idx_q;
    case (state_q)
      FILL: begin
        ready_c = 1'b1;
        if (ip_axis_tvalid) begin
          wr_en = 1'b1;
          if (beat_idx_q == LAST_IDX) begin
            beat_idx_d = '0;
            state_d    = HOLD;
          end else begin
            beat_idx_d = IDX_W'(beat_idx_q + 1'b1);
          end
        end
      end
      HOLD: begin
        valid_c = 1'b1;
        // Input is only accepted when the held window leaves, so slot 0 can be
        // refilled in the same cycle without a bubble.
        ready_c = op_axis_tready;
        if (op_axis_tready) begin
          state_d = FILL;
          if (ip_axis_tvalid) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (WIN_BEATS == 1) begin
              beat_idx_d = '0;
              state_d    = HOLD;
            end else begin
              beat_idx_d = IDX_W'(1);
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign op_hs = valid_c && op_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      beat_idx_q   <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      frame_done_q <= op_hs && op_axis_tlast;
      if (wr_en) data_q[wr_idx*BEAT_W +: BEAT_W] <= ip_axis_tdata;
    end
  end

  swu_pixel_counter #(
    .WIDTH (OFMWidth),
    .HEIGHT(OFMHeight)
  ) u_pixel_counter (
    .clk       (clk),
    .reset     (reset),
    .adv_i     (op_hs),
    .col_o     (op_col),
    .row_o     (op_row),
    .col_last_o(col_last),
    .row_last_o(row_last)
  );

  assign ip_axis_tready = ready_c && !reset;
  assign op_axis_tvalid = valid_c;
  assign op_axis_tlast  = valid_c && col_last && row_last;
  assign op_axis_tdata  = data_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_swu_window_collector.sv
// Scoreboard bench for swu_window_collector: default geometry plus a
// SIMD=2 / 1x1-kernel instance sharing clock and reset.
module tb_swu_window_collector;

  localparam int WB = 18;
  localparam int OW = WB * 8;

  typedef struct {
    logic [OW-1:0] d;
    int            col;
    int            row;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    ip_data = '0;
  logic          ip_valid = 1'b0;
  logic          ip_ready;
  logic [OW-1:0] op_data;
  logic          op_valid;
  logic          op_ready = 1'b1;
  logic          op_last;
  logic [1:0]    op_col;
  logic [1:0]    op_row;
  logic          frame_done;

  logic [15:0]   d2_data = '0;
  logic          d2_valid = 1'b0;
  logic          d2_ready;
  logic [31:0]   d2_op_data;
  logic          d2_op_valid;
  logic          d2_op_last;
  logic [1:0]    d2_col;
  logic [1:0]    d2_row;
  logic          d2_frame_done;

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   win_n = 0;
  int   fd_count = 0;
  bit   mon_en = 1'b0;
  bit   fd_pend = 1'b0;
  exp_t sb_q[$];

  swu_window_collector dut (
    .clk(clk), .reset(reset),
    .ip_axis_tdata(ip_data), .ip_axis_tvalid(ip_valid), .ip_axis_tready(ip_ready),
    .op_axis_tdata(op_data), .op_axis_tvalid(op_valid), .op_axis_tready(op_ready),
    .op_axis_tlast(op_last), .op_col(op_col), .op_row(op_row), .frame_done(frame_done)
  );

  swu_window_collector #(
    .SIMD(2), .IFMChannels(4), .KERNEL_HEIGHT(1), .KERNEL_WIDTH(1)
  ) dut2 (
    .clk(clk), .reset(reset),
    .ip_axis_tdata(d2_data), .ip_axis_tvalid(d2_valid), .ip_axis_tready(d2_ready),
    .op_axis_tdata(d2_op_data), .op_axis_tvalid(d2_op_valid), .op_axis_tready(1'b1),
    .op_axis_tlast(d2_op_last), .op_col(d2_col), .op_row(d2_row), .frame_done(d2_frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] mk_win(input logic [7:0] base);
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < WB; i++) w[i*8 +: 8] = base + 8'(i);
    return w;
  endfunction

  // Scoreboard consumer: sampled on the falling edge, when inputs and outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      fd_pend = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_pend);
      if (frame_done) fd_count++;
      fd_pend = 1'b0;
      if (op_valid && op_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_window", op_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("win_data", op_data, e.d);
          chk("win_col", op_col, e.col);
          chk("win_row", op_row, e.row);
          chk("win_tlast", op_last, e.last);
          fd_pend = e.last;
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, output bit ok);
    bit hs;
    ok = 1'b0;
    ip_valid = 1'b1;
    ip_data  = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      hs = ip_ready;
      @(posedge clk);
      #1;
      if (hs) ok = 1'b1;
    end
    ip_valid = 1'b0;
    if (!ok) chk("beat_timeout", ok, 1'b1);
  endtask

  task automatic send_window(input logic [7:0] base, input int gap, output int tf, output int tl);
    bit   ok;
    exp_t e;
    tf = 0;
    tl = 0;
    for (int i = 0; i < WB; i++) begin
      send_beat(base + 8'(i), ok);
      if (i == 0) tf = cyc;
      if (i == WB - 1) tl = cyc;
      if (i < WB - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    e.d    = mk_win(base);
    e.col  = win_n % 3;
    e.row  = (win_n / 3) % 3;
    e.last = (win_n % 9 == 8);
    sb_q.push_back(e);
    win_n++;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    reset    = 1'b1;
    ip_valid = 1'b0;
    d2_valid = 1'b0;
    @(negedge clk);
    chk("rst_ip_ready", ip_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_tvalid", op_valid, 1'b0);
    chk("rst_tlast", op_last, 1'b0);
    chk("rst_tdata", op_data, '0);
    chk("rst_col", op_col, 0);
    chk("rst_row", op_row, 0);
    chk("rst_frame_done", frame_done, 1'b0);
    sb_q.delete();
    win_n  = 0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ip_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  tf, tl, prev_tl, rel;
    bit  ok;
    bit  wait_ok;

    do_reset();

    // First window: latency and slot ordering.
    send_window(8'h00, 0, tf, tl);
    chk("lat_tvalid", op_valid, 1'b1);
    chk("first_lsb", op_data[7:0], 8'h00);
    chk("first_msb", op_data[143:136], 8'h11);
    chk("first_col", op_col, 0);
    chk("first_row", op_row, 0);
    chk("first_tlast", op_last, 1'b0);

    // Rest of the frame plus window 10, back to back.
    prev_tl = tl;
    for (int w = 1; w < 10; w++) begin
      send_window(8'(w * 18), 0, tf, tl);
      chk("win_interval", tl - prev_tl, 18);
      prev_tl = tl;
    end
    chk("win10_col", op_col, 0);
    chk("win10_row", op_row, 0);
    @(posedge clk);
    #1;
    chk("frame_done_count", fd_count, 1);

    // Backpressure while the next window is waiting.
    op_ready = 1'b0;
    send_window(8'h40, 0, tf, tl);
    ip_valid = 1'b1;
    ip_data  = 8'h60;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ip_ready", ip_ready, 1'b0);
      chk("bp_tvalid", op_valid, 1'b1);
      chk("bp_data_stable", op_data, mk_win(8'h40));
      @(posedge clk);
      #1;
    end
    op_ready = 1'b1;
    rel = cyc;
    send_window(8'h60, 0, tf, tl);
    chk("bp_first_accept", tf - rel, 1);

    // Input gaps: valid every other cycle.
    send_window(8'h80, 1, tf, tl);
    chk("gap_span", tl - tf, 34);

    // Reset after a partial window.
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) send_beat(8'hE0 + 8'(i), ok);
    do_reset();
    send_window(8'hA0, 0, tf, tl);
    chk("rst_mid_data", op_data, mk_win(8'hA0));
    chk("rst_mid_col", op_col, 0);
    chk("rst_mid_row", op_row, 0);

    // SIMD=2, 1x1 kernel: two beats per window.
    @(posedge clk);
    #1;
    d2_valid = 1'b1;
    d2_data  = 16'h0201;
    @(negedge clk);
    chk("s2_ready0", d2_ready, 1'b1);
    @(posedge clk);
    #1;
    d2_data = 16'h0403;
    @(negedge clk);
    chk("s2_ready1", d2_ready, 1'b1);
    @(posedge clk);
    #1;
    d2_valid = 1'b0;
    chk("s2_tvalid", d2_op_valid, 1'b1);
    chk("s2_tdata", d2_op_data, 32'h04030201);

    wait_ok = 1'b0;
    for (int n = 0; n < 50 && !wait_ok; n++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) wait_ok = 1'b1;
    end
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
